// File: rtl/spram_arbiter_if.sv
// Requester-side bus of spram_arbiter: one command in, grant/read-data back.
// master = bus master (requester), slave = arbiter.
interface spram_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/spram_arbiter.sv
// Two-requester arbiter/sequencer for a single-port sync RAM with a 1-cycle read.
// Define SPRAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default round robin.
module spram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    spram_arbiter_if.slave        rq0,
    spram_arbiter_if.slave        rq1,
    output logic                  o_ram_cs,
    output logic                  o_ram_we,
    output logic                  o_ram_oe,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_wdata,
    input  logic [DATA_WIDTH-1:0] i_ram_rdata
);

    typedef enum logic [1:0] {StIdle, StIssue, StRdata} state_e;

    state_e                r_state, w_state_nxt;
    logic [1:0]            w_req;
    logic                  w_win;
    logic                  r_win, w_win_nxt;
    logic                  r_cmd_we, w_cmd_we_nxt;
    logic [ADDR_WIDTH-1:0] r_cmd_addr, w_cmd_addr_nxt;
    logic [DATA_WIDTH-1:0] r_cmd_wdata, w_cmd_wdata_nxt;
    logic [1:0]            r_gnt, w_gnt_nxt;
    logic [1:0]            r_rvalid, w_rvalid_nxt;
    logic                  r_ram_cs, w_ram_cs_nxt;
    logic                  r_ram_we, w_ram_we_nxt;
    logic                  r_ram_oe, w_ram_oe_nxt;
    logic                  w_capture;
    logic [DATA_WIDTH-1:0] r_rdata0, r_rdata1;

    assign w_req = {rq1.req, rq0.req};

`ifdef SPRAM_ARB_FIXED_PRIO_EN
    assign w_win = ~w_req[0];
`else
    logic r_last_win;

    // Tie goes to the port that did not win last; reset value 1 hands the first tie to port 0.
    assign w_win = (&w_req) ? ~r_last_win : w_req[1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_win <= 1'b1;
        end else if (r_state == StIdle && (|w_req)) begin
            r_last_win <= w_win;
        end
    end
`endif

    // Outputs are computed one cycle ahead so every pin comes straight from a flop.
    always_comb begin
        w_state_nxt     = r_state;
        w_win_nxt       = r_win;
        w_cmd_we_nxt    = r_cmd_we;
        w_cmd_addr_nxt  = r_cmd_addr;
        w_cmd_wdata_nxt = r_cmd_wdata;
        w_gnt_nxt       = 2'b00;
        w_rvalid_nxt    = 2'b00;
        w_ram_cs_nxt    = 1'b0;
        w_ram_we_nxt    = 1'b0;
        w_ram_oe_nxt    = 1'b0;
        w_capture       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (|w_req) begin
                    w_state_nxt       = StIssue;
                    w_win_nxt         = w_win;
                    w_cmd_we_nxt      = w_win ? rq1.we    : rq0.we;
                    w_cmd_addr_nxt    = w_win ? rq1.addr  : rq0.addr;
                    w_cmd_wdata_nxt   = w_win ? rq1.wdata : rq0.wdata;
                    w_gnt_nxt[w_win]  = 1'b1;
                    w_ram_cs_nxt      = 1'b1;
                    w_ram_we_nxt      = w_cmd_we_nxt;
                end
            end
            StIssue: begin
                if (r_cmd_we) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_state_nxt  = StRdata;
                    w_ram_cs_nxt = 1'b1;
                    w_ram_oe_nxt = 1'b1;
                end
            end
            StRdata: begin
                w_state_nxt         = StIdle;
                w_rvalid_nxt[r_win] = 1'b1;
                w_capture           = 1'b1;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_win       <= 1'b0;
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_gnt       <= 2'b00;
            r_rvalid    <= 2'b00;
            r_ram_cs    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_oe    <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_win       <= w_win_nxt;
            r_cmd_we    <= w_cmd_we_nxt;
            r_cmd_addr  <= w_cmd_addr_nxt;
            r_cmd_wdata <= w_cmd_wdata_nxt;
            r_gnt       <= w_gnt_nxt;
            r_rvalid    <= w_rvalid_nxt;
            r_ram_cs    <= w_ram_cs_nxt;
            r_ram_we    <= w_ram_we_nxt;
            r_ram_oe    <= w_ram_oe_nxt;
            if (w_capture) begin
                if (r_win) begin
                    r_rdata1 <= i_ram_rdata;
                end else begin
                    r_rdata0 <= i_ram_rdata;
                end
            end
        end
    end

    assign rq0.gnt     = r_gnt[0];
    assign rq1.gnt     = r_gnt[1];
    assign rq0.rvalid  = r_rvalid[0];
    assign rq1.rvalid  = r_rvalid[1];
    assign rq0.rdata   = r_rdata0;
    assign rq1.rdata   = r_rdata1;
    assign o_ram_cs    = r_ram_cs;
    assign o_ram_we    = r_ram_we;
    assign o_ram_oe    = r_ram_oe;
    assign o_ram_addr  = r_cmd_addr;
    assign o_ram_wdata = r_cmd_wdata;

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter with a behavioural single-port sync RAM model.
// Honours SPRAM_ARB_FIXED_PRIO_EN for the tie-break expectations.
`timescale 1ns/1ps
module tb_spram_arbiter;
    localparam int AW = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rq0_if ();
    spram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rq1_if ();

    logic          ram_cs, ram_we, ram_oe;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata, ram_q;
    logic [DW-1:0] mem [16];

    int checks = 0;
    int errors = 0;

    spram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .rq0         (rq0_if),
        .rq1         (rq1_if),
        .o_ram_cs    (ram_cs),
        .o_ram_we    (ram_we),
        .o_ram_oe    (ram_oe),
        .o_ram_addr  (ram_addr),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata)
    );

    // RAM model: registered read on cs&!we, output gated by oe
    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_cs && !ram_we) ram_q <= mem[ram_addr];
    end
    assign ram_rdata = (ram_cs && ram_oe && !ram_we) ? ram_q : '0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic req, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            rq0_if.req = req; rq0_if.we = we; rq0_if.addr = a; rq0_if.wdata = d;
        end else begin
            rq1_if.req = req; rq1_if.we = we; rq1_if.addr = a; rq1_if.wdata = d;
        end
    endtask

    task automatic test_reset;
        logic [106:0] v;
        tick; tick;
        v = {rq0_if.gnt, rq0_if.rvalid, rq1_if.gnt, rq1_if.rvalid, ram_cs, ram_we, ram_oe,
             ram_addr, ram_wdata, rq0_if.rdata, rq1_if.rdata};
        checks++;
        if (v !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", v); end
        rst = 1'b0;
        set_req(0, 1, 1, 4'd1, 32'h1111_1111);
        set_req(1, 1, 1, 4'd2, 32'h2222_2222);
        tick;
        checks++;
        if ({rq1_if.gnt, rq0_if.gnt} !== 2'b01) begin
            errors++; $display("FAIL first_tie gnt got %b want 01", {rq1_if.gnt, rq0_if.gnt});
        end
        tick; tick;
        rst = 1'b1;
        set_req(0, 0, 0, 4'd0, 32'h0);
        set_req(1, 0, 0, 4'd0, 32'h0);
        for (int c = 0; c < 2; c++) begin
            tick;
            v = {rq0_if.gnt, rq0_if.rvalid, rq1_if.gnt, rq1_if.rvalid, ram_cs, ram_we, ram_oe,
                 ram_addr, ram_wdata, rq0_if.rdata, rq1_if.rdata};
            checks++;
            if (v !== '0) begin errors++; $display("FAIL midreset_outputs c%0d got %h want 0", c, v); end
        end
        rst = 1'b0;
        set_req(1, 1, 1, 4'd7, 32'h0000_0077);
        tick;
        checks++;
        if ({rq1_if.gnt, ram_cs, ram_we, ram_addr} !== {3'b111, 4'd7}) begin
            errors++;
            $display("FAIL post_reset_serve got gnt1=%b cs=%b we=%b addr=%0d want 1 1 1 7",
                     rq1_if.gnt, ram_cs, ram_we, ram_addr);
        end
        set_req(1, 0, 0, 4'd0, 32'h0);
        tick;
    endtask

    task automatic test_write_read;
        set_req(0, 1, 1, 4'd3, 32'hDEAD_BEEF);
        tick;
        checks++;
        if ({rq0_if.gnt, ram_cs, ram_we, ram_oe, ram_addr, ram_wdata} !== {4'b1110, 4'd3, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL wr_issue got gnt=%b cs=%b we=%b oe=%b addr=%0d wdata=%h want 1 1 1 0 3 deadbeef",
                     rq0_if.gnt, ram_cs, ram_we, ram_oe, ram_addr, ram_wdata);
        end
        set_req(0, 0, 0, 4'd0, 32'h0);
        tick;
        set_req(1, 1, 0, 4'd3, 32'h0);
        tick;
        checks++;
        if ({rq1_if.gnt, rq0_if.gnt, ram_cs, ram_we, ram_oe} !== 5'b10100) begin
            errors++;
            $display("FAIL rd_issue got gnt1=%b gnt0=%b cs=%b we=%b oe=%b want 1 0 1 0 0",
                     rq1_if.gnt, rq0_if.gnt, ram_cs, ram_we, ram_oe);
        end
        set_req(1, 0, 0, 4'd0, 32'h0);
        tick;
        checks++;
        if ({ram_cs, ram_we, ram_oe, ram_addr} !== {3'b101, 4'd3}) begin
            errors++;
            $display("FAIL rd_rdata_phase got cs=%b we=%b oe=%b addr=%0d want 1 0 1 3",
                     ram_cs, ram_we, ram_oe, ram_addr);
        end
        tick;
        checks++;
        if ({rq1_if.rvalid, rq0_if.rvalid, rq1_if.rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL rd_rvalid got rv1=%b rv0=%b rdata1=%h want 1 0 deadbeef",
                     rq1_if.rvalid, rq0_if.rvalid, rq1_if.rdata);
        end
        tick;
        checks++;
        if ({rq1_if.rvalid, rq1_if.rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL rd_hold got rv1=%b rdata1=%h want 0 deadbeef", rq1_if.rvalid, rq1_if.rdata);
        end
    endtask

    task automatic test_round_robin;
        logic e0, e1;
        set_req(0, 1, 1, 4'd1, 32'hAAAA_0001);
        set_req(1, 1, 1, 4'd2, 32'hBBBB_0002);
        for (int c = 1; c <= 7; c++) begin
            tick;
`ifdef SPRAM_ARB_FIXED_PRIO_EN
            e0 = (c % 2) == 1;
            e1 = 1'b0;
`else
            e0 = (c == 1) || (c == 5);
            e1 = (c == 3) || (c == 7);
`endif
            checks++;
            if ({rq0_if.gnt, rq1_if.gnt} !== {e0, e1}) begin
                errors++;
                $display("FAIL rr_gnt c%0d got gnt0=%b gnt1=%b want %b %b", c, rq0_if.gnt, rq1_if.gnt, e0, e1);
            end
            if (e0 || e1) begin
                checks++;
                if (ram_addr !== (e0 ? 4'd1 : 4'd2)) begin
                    errors++;
                    $display("FAIL rr_addr c%0d got %0d want %0d", c, ram_addr, e0 ? 1 : 2);
                end
            end
        end
        set_req(0, 0, 0, 4'd0, 32'h0);
        set_req(1, 0, 0, 4'd0, 32'h0);
        tick;
        checks++;
        if ({rq0_if.gnt, rq1_if.gnt, ram_cs} !== 3'b000) begin
            errors++;
            $display("FAIL rr_idle got gnt0=%b gnt1=%b cs=%b want 0 0 0", rq0_if.gnt, rq1_if.gnt, ram_cs);
        end
    endtask

    task automatic test_read_then_write;
        logic [5:0] e;
        set_req(0, 1, 0, 4'd15, 32'h0);
        for (int c = 1; c <= 5; c++) begin
            tick;
            // expected {gnt0, rvalid0, cs, we, oe, addr==?} per cycle
            case (c)
                1: e = 6'b101001;
                2: e = 6'b001011;
                3: e = 6'b010001;
                4: e = 6'b101101;
                default: e = 6'b000000;
            endcase
            checks++;
            if ({rq0_if.gnt, rq0_if.rvalid, ram_cs, ram_we, ram_oe,
                 (ram_addr == ((c >= 4) ? 4'd0 : 4'd15))} !== e && !(c == 5 && {rq0_if.gnt,
                 rq0_if.rvalid, ram_cs, ram_we, ram_oe} === 5'b0)) begin
                errors++;
                $display("FAIL rw_seq c%0d got gnt0=%b rv0=%b cs=%b we=%b oe=%b addr=%0d want %b",
                         c, rq0_if.gnt, rq0_if.rvalid, ram_cs, ram_we, ram_oe, ram_addr, e);
            end
            checks++;
            if (ram_we && ram_oe) begin errors++; $display("FAIL we_oe_both c%0d got 1 want 0", c); end
            if (c == 1) set_req(0, 1, 1, 4'd0, 32'h1234_5678);
            if (c == 3) begin
                checks++;
                if (rq0_if.rdata !== 32'h0000_100F) begin
                    errors++; $display("FAIL rw_rdata got %h want 0000100f", rq0_if.rdata);
                end
            end
            if (c == 4) begin
                checks++;
                if (ram_wdata !== 32'h1234_5678) begin
                    errors++; $display("FAIL rw_wdata got %h want 12345678", ram_wdata);
                end
                set_req(0, 0, 0, 4'd0, 32'h0);
            end
        end
    endtask

    task automatic test_reset_in_rdata;
        set_req(1, 1, 0, 4'd5, 32'h0);
        tick;
        set_req(1, 0, 0, 4'd0, 32'h0);
        tick;
        checks++;
        if ({ram_cs, ram_oe, ram_addr} !== {2'b11, 4'd5}) begin
            errors++; $display("FAIL abort_pre got cs=%b oe=%b addr=%0d want 1 1 5", ram_cs, ram_oe, ram_addr);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if ({rq1_if.rvalid, rq0_if.rvalid, ram_cs, ram_oe, rq1_if.rdata} !== '0) begin
            errors++;
            $display("FAIL abort_rdata got rv1=%b rv0=%b cs=%b oe=%b rdata1=%h want 0 0 0 0 0",
                     rq1_if.rvalid, rq0_if.rvalid, ram_cs, ram_oe, rq1_if.rdata);
        end
        tick;
        checks++;
        if ({rq1_if.rvalid, ram_cs} !== 2'b00) begin
            errors++; $display("FAIL abort_after got rv1=%b cs=%b want 0 0", rq1_if.rvalid, ram_cs);
        end
    endtask

    task automatic test_fill_readback;
        logic [DW-1:0] e;
        logic          g;
        for (int a = 0; a < 16; a++) begin
            e = 32'(a) ^ 32'hA5A5_A5A5;
            set_req(a % 2, 1, 1, 4'(a), e);
            tick;
            g = (a % 2) ? rq1_if.gnt : rq0_if.gnt;
            checks++;
            if ({g, ram_we, ram_addr, ram_wdata} !== {2'b11, 4'(a), e}) begin
                errors++;
                $display("FAIL fill_wr a%0d got gnt=%b we=%b addr=%0d wdata=%h want 1 1 %0d %h",
                         a, g, ram_we, ram_addr, ram_wdata, a, e);
            end
            set_req(a % 2, 0, 0, 4'd0, 32'h0);
            tick;
        end
        for (int a = 0; a < 16; a++) begin
            e = 32'(a) ^ 32'hA5A5_A5A5;
            set_req(a % 2, 1, 0, 4'(a), 32'h0);
            tick;
            set_req(a % 2, 0, 0, 4'd0, 32'h0);
            tick; tick;
            checks++;
            if ((a % 2) ? ({rq1_if.rvalid, rq1_if.rdata} !== {1'b1, e})
                        : ({rq0_if.rvalid, rq0_if.rdata} !== {1'b1, e})) begin
                errors++;
                $display("FAIL fill_rd a%0d got rv=%b rdata=%h want 1 %h", a,
                         (a % 2) ? rq1_if.rvalid : rq0_if.rvalid,
                         (a % 2) ? rq1_if.rdata : rq0_if.rdata, e);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        ram_q = '0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0000_1000 + 32'(i);
        set_req(0, 0, 0, 4'd0, 32'h0);
        set_req(1, 0, 0, 4'd0, 32'h0);
        test_reset;
        test_write_read;
        test_round_robin;
        test_read_then_write;
        test_reset_in_rdata;
        test_fill_readback;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
